// File: rtl/riscv_i32_alu_arbiter_pkg.sv
// Shared types for the two-requester RV32I ALU arbiter.
// Encodings, requester id and the issue/response entry layouts.
package riscv_alu_arb_pkg;

    localparam logic [3:0] OP_NONE   = 4'd0;
    localparam logic [3:0] OP_ALU    = 4'd1;
    localparam logic [3:0] OP_BRANCH = 4'd2;
    localparam logic [3:0] OP_JAL    = 4'd3;
    localparam logic [3:0] OP_LUI    = 4'd4;
    localparam logic [3:0] OP_AUIPC  = 4'd5;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    localparam logic [3:0] BR_BEQ  = 4'd0;
    localparam logic [3:0] BR_BNE  = 4'd1;
    localparam logic [3:0] BR_BLT  = 4'd2;
    localparam logic [3:0] BR_BGE  = 4'd3;
    localparam logic [3:0] BR_BLTU = 4'd4;
    localparam logic [3:0] BR_BGEU = 4'd5;

    typedef logic req_id_t;

    typedef struct packed {
        logic [3:0]  op;
        logic [3:0]  subop;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        imm_valid;
        logic [4:0]  imm_shift;
        logic        is_compressed;
        req_id_t     id;
    } iss_entry_t;

    typedef struct packed {
        req_id_t     id;
        logic [31:0] result;
        logic        branch_met;
    } rsp_entry_t;

endpackage

// File: rtl/riscv_i32_alu_arbiter_if.sv
// Request channel into the ALU arbiter: valid/ready plus operand bundle.
// The requester drives the master side, the arbiter the slave side.
interface riscv_i32_alu_arbiter_if #(
    parameter int TAG_W = 4
);
    logic             valid;
    logic             ready;
    logic [3:0]       op;
    logic [3:0]       subop;
    logic [31:0]      rs1;
    logic [31:0]      rs2;
    logic [31:0]      pc;
    logic [31:0]      imm;
    logic             imm_valid;
    logic [4:0]       imm_shift;
    logic             is_compressed;
    logic [TAG_W-1:0] tag;

    modport master (
        output valid, op, subop, rs1, rs2, pc, imm,
        output imm_valid, imm_shift, is_compressed, tag,
        input  ready
    );

    modport slave (
        input  valid, op, subop, rs1, rs2, pc, imm,
        input  imm_valid, imm_shift, is_compressed, tag,
        output ready
    );
endinterface

// File: rtl/riscv_i32_alu_rr_pick.sv
// Two-way round-robin pick; purely combinational.
// The requester that did not win last time wins a tie.
module riscv_i32_alu_rr_pick
    import riscv_alu_arb_pkg::*;
(
    input  logic [1:0] valid,
    input  req_id_t    last_grant,
    output req_id_t    grant,
    output logic       grant_valid
);

    always_comb begin
        grant       = 1'b0;
        grant_valid = |valid;
        case (valid)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_grant;
            default: grant = 1'b0;
        endcase
    end

endmodule

// File: rtl/riscv_i32_alu_arbiter.sv
// Shares one RV32I ALU between two requesters: issue reg -> ALU -> rsp reg.
// Optional stall counter: RISCV_ALU_ARB_STALL_COUNT_EN.
module riscv_i32_alu_arbiter
    import riscv_alu_arb_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    riscv_i32_alu_arbiter_if.slave req0,
    riscv_i32_alu_arbiter_if.slave req1,
    output logic [3:0]           alu_op,
    output logic [3:0]           alu_subop,
    output logic [31:0]          alu_rs1,
    output logic [31:0]          alu_rs2,
    output logic [31:0]          alu_pc,
    output logic [31:0]          alu_imm,
    output logic                 alu_imm_valid,
    output logic                 alu_is_compressed,
    output logic [4:0]           alu_imm_shift,
    input  logic [31:0]          alu_result,
    input  logic                 alu_branch_met,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [TAG_W-1:0]     rsp_tag,
    output logic [31:0]          rsp_result,
    output logic                 rsp_branch_met,
    output logic [31:0]          stall_count
);

    iss_entry_t       iss_q, iss_d;
    logic             iss_valid_q, iss_valid_d;
    logic [TAG_W-1:0] iss_tag_q, iss_tag_d;
    rsp_entry_t       rsp_q, rsp_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
    req_id_t          last_grant_q, last_grant_d;

    req_id_t    grant;
    logic       grant_valid;
    logic       advance;
    logic       iss_ready;
    logic       accept;
    iss_entry_t req_e0, req_e1;

    riscv_i32_alu_rr_pick u_pick (
        .valid       ({req1.valid, req0.valid}),
        .last_grant  (last_grant_q),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    assign advance   = !rsp_valid_q | rsp_ready;
    assign iss_ready = !iss_valid_q | advance;

    assign req0.ready = grant_valid & (grant == 1'b0) & req0.valid
                      & iss_ready & !flush;
    assign req1.ready = grant_valid & (grant == 1'b1) & req1.valid
                      & iss_ready & !flush;
    assign accept = (req0.valid & req0.ready) | (req1.valid & req1.ready);

    always_comb begin
        req_e0.op            = req0.op;
        req_e0.subop         = req0.subop;
        req_e0.rs1           = req0.rs1;
        req_e0.rs2           = req0.rs2;
        req_e0.pc            = req0.pc;
        req_e0.imm           = req0.imm;
        req_e0.imm_valid     = req0.imm_valid;
        req_e0.imm_shift     = req0.imm_shift;
        req_e0.is_compressed = req0.is_compressed;
        req_e0.id            = 1'b0;
        req_e1.op            = req1.op;
        req_e1.subop         = req1.subop;
        req_e1.rs1           = req1.rs1;
        req_e1.rs2           = req1.rs2;
        req_e1.pc            = req1.pc;
        req_e1.imm           = req1.imm;
        req_e1.imm_valid     = req1.imm_valid;
        req_e1.imm_shift     = req1.imm_shift;
        req_e1.is_compressed = req1.is_compressed;
        req_e1.id            = 1'b1;
    end

    // Flush drops both valids but leaves payloads stale on purpose.
    always_comb begin
        iss_d        = iss_q;
        iss_valid_d  = iss_valid_q;
        iss_tag_d    = iss_tag_q;
        rsp_d        = rsp_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_tag_d    = rsp_tag_q;
        last_grant_d = last_grant_q;
        if (flush) begin
            iss_valid_d = 1'b0;
            rsp_valid_d = 1'b0;
        end else begin
            if (iss_valid_q && advance) begin
                rsp_d.id         = iss_q.id;
                rsp_d.result     = alu_result;
                rsp_d.branch_met = alu_branch_met;
                rsp_tag_d        = iss_tag_q;
                rsp_valid_d      = 1'b1;
                iss_valid_d      = 1'b0;
            end else if (rsp_valid_q && rsp_ready) begin
                rsp_valid_d = 1'b0;
            end
            if (accept) begin
                iss_d        = grant ? req_e1 : req_e0;
                iss_tag_d    = grant ? req1.tag : req0.tag;
                iss_valid_d  = 1'b1;
                last_grant_d = grant;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            iss_q        <= '0;
            iss_valid_q  <= 1'b0;
            iss_tag_q    <= '0;
            rsp_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_tag_q    <= '0;
            last_grant_q <= 1'b1;
        end else begin
            iss_q        <= iss_d;
            iss_valid_q  <= iss_valid_d;
            iss_tag_q    <= iss_tag_d;
            rsp_q        <= rsp_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_tag_q    <= rsp_tag_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign alu_op            = iss_q.op;
    assign alu_subop         = iss_q.subop;
    assign alu_rs1           = iss_q.rs1;
    assign alu_rs2           = iss_q.rs2;
    assign alu_pc            = iss_q.pc;
    assign alu_imm           = iss_q.imm;
    assign alu_imm_valid     = iss_q.imm_valid;
    assign alu_is_compressed = iss_q.is_compressed;
    assign alu_imm_shift     = iss_q.imm_shift;

    assign rsp_valid      = rsp_valid_q;
    assign rsp_id         = rsp_q.id;
    assign rsp_tag        = rsp_tag_q;
    assign rsp_result     = rsp_q.result;
    assign rsp_branch_met = rsp_q.branch_met;

`ifdef RISCV_ALU_ARB_STALL_COUNT_EN
    logic [31:0] stall_q, stall_d;

    // Saturating count of cycles where someone asked and nobody got in.
    always_comb begin
        stall_d = stall_q;
        if ((req0.valid | req1.valid) && !accept && (stall_q != 32'hffffffff))
            stall_d = stall_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) stall_q <= '0;
        else       stall_q <= stall_d;
    end

    assign stall_count = stall_q;
`else
    assign stall_count = 32'h0;
`endif

endmodule

// File: tb/tb_riscv_i32_alu_arbiter.sv
// Directed bench for riscv_i32_alu_arbiter with a small behavioural ALU.
// Honours RISCV_ALU_ARB_STALL_COUNT_EN for the stall counter expectation.
module tb_riscv_i32_alu_arbiter;
    import riscv_alu_arb_pkg::*;

`ifdef RISCV_ALU_ARB_STALL_COUNT_EN
    localparam logic [31:0] EXP_STALL = 32'd8;
`else
    localparam logic [31:0] EXP_STALL = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic [3:0]  alu_op, alu_subop;
    logic [31:0] alu_rs1, alu_rs2, alu_pc, alu_imm;
    logic        alu_imm_valid, alu_is_compressed;
    logic [4:0]  alu_imm_shift;
    logic [31:0] alu_result;
    logic        alu_branch_met;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_id;
    logic [3:0]  rsp_tag;
    logic [31:0] rsp_result;
    logic        rsp_branch_met;
    logic [31:0] stall_count;
    logic [31:0] opb;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        int          id;
        int          tag;
        logic [31:0] res;
        logic        br;
        int          cyc;
    } rsp_rec_t;

    rsp_rec_t rsp_log[$];
    int       acc_log[$];

    riscv_i32_alu_arbiter_if #(.TAG_W(4)) req0_if ();
    riscv_i32_alu_arbiter_if #(.TAG_W(4)) req1_if ();

    riscv_i32_alu_arbiter #(.TAG_W(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .flush             (flush),
        .req0              (req0_if),
        .req1              (req1_if),
        .alu_op            (alu_op),
        .alu_subop         (alu_subop),
        .alu_rs1           (alu_rs1),
        .alu_rs2           (alu_rs2),
        .alu_pc            (alu_pc),
        .alu_imm           (alu_imm),
        .alu_imm_valid     (alu_imm_valid),
        .alu_is_compressed (alu_is_compressed),
        .alu_imm_shift     (alu_imm_shift),
        .alu_result        (alu_result),
        .alu_branch_met    (alu_branch_met),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .rsp_id            (rsp_id),
        .rsp_tag           (rsp_tag),
        .rsp_result        (rsp_result),
        .rsp_branch_met    (rsp_branch_met),
        .stall_count       (stall_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        opb            = alu_imm_valid ? alu_imm : alu_rs2;
        alu_result     = 32'h0;
        alu_branch_met = 1'b0;
        case (alu_op)
            OP_ALU: begin
                case (alu_subop)
                    ALU_ADD: alu_result = alu_rs1 + opb;
                    ALU_SUB: alu_result = alu_rs1 - opb;
                    ALU_AND: alu_result = alu_rs1 & opb;
                    ALU_XOR: alu_result = alu_rs1 ^ opb;
                    ALU_SLL: alu_result = alu_rs1 << (alu_imm_valid ? alu_imm_shift : opb[4:0]);
                    default: alu_result = 32'h0;
                endcase
            end
            OP_BRANCH: begin
                alu_result = alu_pc + alu_imm;
                case (alu_subop)
                    BR_BEQ:  alu_branch_met = (alu_rs1 == alu_rs2);
                    BR_BNE:  alu_branch_met = (alu_rs1 != alu_rs2);
                    BR_BLT:  alu_branch_met = ($signed(alu_rs1) < $signed(alu_rs2));
                    BR_BLTU: alu_branch_met = (alu_rs1 < alu_rs2);
                    default: alu_branch_met = 1'b0;
                endcase
            end
            OP_JAL: alu_result = alu_pc + (alu_is_compressed ? 32'd2 : 32'd4);
            default: alu_result = 32'h0;
        endcase
    end

    // Observe handshakes late in each cycle, after inputs have settled.
    always @(negedge clk) begin
        rsp_rec_t r;
        #4;
        if (!reset) begin
            if (req0_if.valid && req0_if.ready) acc_log.push_back(0);
            if (req1_if.valid && req1_if.ready) acc_log.push_back(1);
            if (rsp_valid && rsp_ready) begin
                r.id  = int'(rsp_id);
                r.tag = int'(rsp_tag);
                r.res = rsp_result;
                r.br  = rsp_branch_met;
                r.cyc = cyc;
                rsp_log.push_back(r);
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_req(input int n, input logic v, input logic [3:0] op,
                           input logic [3:0] sub, input logic [31:0] rs1,
                           input logic [31:0] rs2, input logic [31:0] pc,
                           input logic [31:0] imm, input logic iv,
                           input logic ic, input logic [3:0] tag);
        if (n == 0) begin
            req0_if.valid = v; req0_if.op = op; req0_if.subop = sub;
            req0_if.rs1 = rs1; req0_if.rs2 = rs2; req0_if.pc = pc;
            req0_if.imm = imm; req0_if.imm_valid = iv; req0_if.imm_shift = 5'd0;
            req0_if.is_compressed = ic; req0_if.tag = tag;
        end else begin
            req1_if.valid = v; req1_if.op = op; req1_if.subop = sub;
            req1_if.rs1 = rs1; req1_if.rs2 = rs2; req1_if.pc = pc;
            req1_if.imm = imm; req1_if.imm_valid = iv; req1_if.imm_shift = 5'd0;
            req1_if.is_compressed = ic; req1_if.tag = tag;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        flush = 1'b0;
        req0_if.valid = 1'b0;
        req1_if.valid = 1'b0;
        step();
        step();
        reset = 1'b0;
        acc_log.delete();
        rsp_log.delete();
    endtask

    task automatic test_reset();
        set_req(0, 1'b0, OP_ALU, ALU_ADD, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0);
        set_req(1, 1'b0, OP_ALU, ALU_ADD, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0);
        reset = 1'b1;
        step();
        step();
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid got=%0h exp=0", rsp_valid); end
        checks++; if (rsp_id !== 1'b0) begin failures++; $display("FAIL rst_rsp_id got=%0h exp=0", rsp_id); end
        checks++; if (rsp_tag !== 4'h0) begin failures++; $display("FAIL rst_rsp_tag got=%0h exp=0", rsp_tag); end
        checks++; if (rsp_result !== 32'h0) begin failures++; $display("FAIL rst_rsp_result got=%0h exp=0", rsp_result); end
        checks++; if (rsp_branch_met !== 1'b0) begin failures++; $display("FAIL rst_rsp_br got=%0h exp=0", rsp_branch_met); end
        checks++; if ({alu_op, alu_rs1, alu_pc} !== 68'h0) begin failures++; $display("FAIL rst_alu got=%0h exp=0", {alu_op, alu_rs1, alu_pc}); end
        checks++; if (stall_count !== 32'h0) begin failures++; $display("FAIL rst_stall got=%0h exp=0", stall_count); end
        reset = 1'b0;
        req0_if.valid = 1'b1;
        req1_if.valid = 1'b1;
        #1;
        checks++; if ({req1_if.ready, req0_if.ready} !== 2'b01) begin failures++; $display("FAIL rst_first_grant got=%0b exp=01", {req1_if.ready, req0_if.ready}); end
        req0_if.valid = 1'b0;
        req1_if.valid = 1'b0;
    endtask

    task automatic test_single_add();
        do_reset();
        rsp_ready = 1'b1;
        set_req(0, 1'b1, OP_ALU, ALU_ADD, 32'd5, 32'd7, 32'h0, 32'h0, 1'b0, 1'b0, 4'd3);
        step();
        req0_if.valid = 1'b0;
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL add_t1_valid got=%0h exp=0", rsp_valid); end
        checks++; if (alu_rs1 !== 32'd5 || alu_op !== OP_ALU) begin failures++; $display("FAIL add_issue got=%0h/%0h exp=5/1", alu_rs1, alu_op); end
        step();
        checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL add_t2_valid got=%0h exp=1", rsp_valid); end
        checks++; if (rsp_result !== 32'd12) begin failures++; $display("FAIL add_result got=%0h exp=c", rsp_result); end
        checks++; if (rsp_id !== 1'b0 || rsp_tag !== 4'd3) begin failures++; $display("FAIL add_id_tag got=%0h/%0h exp=0/3", rsp_id, rsp_tag); end
        step();
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL add_drain got=%0h exp=0", rsp_valid); end
    endtask

    task automatic test_operand_paths();
        do_reset();
        rsp_ready = 1'b1;
        set_req(0, 1'b1, OP_ALU, ALU_ADD, 32'd1, 32'd999, 32'h0, 32'h10, 1'b1, 1'b0, 4'd1);
        step();
        set_req(0, 1'b1, OP_JAL, 4'd0, 32'h0, 32'h0, 32'h100, 32'h0, 1'b0, 1'b1, 4'd2);
        step();
        req0_if.valid = 1'b0;
        repeat (3) step();
        checks++; if (rsp_log.size() !== 2) begin failures++; $display("FAIL ops_count got=%0d exp=2", rsp_log.size()); end
        else begin
            checks++; if (rsp_log[0].res !== 32'h11) begin failures++; $display("FAIL ops_imm got=%0h exp=11", rsp_log[0].res); end
            checks++; if (rsp_log[1].res !== 32'h102) begin failures++; $display("FAIL ops_jal_c got=%0h exp=102", rsp_log[1].res); end
        end
    endtask

    task automatic test_contention();
        int exp_id;
        do_reset();
        rsp_ready = 1'b1;
        set_req(0, 1'b1, OP_ALU, ALU_ADD, 32'd100, 32'd1, 32'h0, 32'h0, 1'b0, 1'b0, 4'hA);
        set_req(1, 1'b1, OP_ALU, ALU_ADD, 32'd200, 32'd2, 32'h0, 32'h0, 1'b0, 1'b0, 4'hB);
        repeat (6) step();
        req0_if.valid = 1'b0;
        req1_if.valid = 1'b0;
        repeat (4) step();
        checks++; if (acc_log.size() !== 6) begin failures++; $display("FAIL cont_accepts got=%0d exp=6", acc_log.size()); end
        for (int i = 0; i < 6 && i < acc_log.size(); i++) begin
            checks++; if (acc_log[i] !== i % 2) begin failures++; $display("FAIL cont_order[%0d] got=%0d exp=%0d", i, acc_log[i], i % 2); end
        end
        checks++; if (rsp_log.size() !== 6) begin failures++; $display("FAIL cont_rsps got=%0d exp=6", rsp_log.size()); end
        for (int i = 0; i < 6 && i < rsp_log.size(); i++) begin
            exp_id = i % 2;
            checks++;
            if (rsp_log[i].id !== exp_id || rsp_log[i].res !== (exp_id == 0 ? 32'd101 : 32'd202) ||
                rsp_log[i].tag !== (exp_id == 0 ? 10 : 11) || (i > 0 && rsp_log[i].cyc !== rsp_log[i-1].cyc + 1)) begin
                failures++;
                $display("FAIL cont_rsp[%0d] got=id%0d res%0d tag%0d exp=id%0d", i, rsp_log[i].id, rsp_log[i].res, rsp_log[i].tag, exp_id);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        rsp_ready = 1'b0;
        set_req(0, 1'b1, OP_ALU, ALU_ADD, 32'd100, 32'd1, 32'h0, 32'h0, 1'b0, 1'b0, 4'h4);
        set_req(1, 1'b1, OP_ALU, ALU_ADD, 32'd200, 32'd2, 32'h0, 32'h0, 1'b0, 1'b0, 4'h5);
        step();
        step();
        checks++; if (rsp_valid !== 1'b1 || rsp_result !== 32'd101) begin failures++; $display("FAIL bp_first got=%0h/%0d exp=1/101", rsp_valid, rsp_result); end
        step();
        step();
        #1;
        checks++; if (rsp_result !== 32'd101 || rsp_id !== 1'b0 || rsp_tag !== 4'h4) begin failures++; $display("FAIL bp_hold got=%0d/%0h/%0h exp=101/0/4", rsp_result, rsp_id, rsp_tag); end
        checks++; if (alu_rs1 !== 32'd200) begin failures++; $display("FAIL bp_iss_hold got=%0d exp=200", alu_rs1); end
        checks++; if ({req1_if.ready, req0_if.ready} !== 2'b00) begin failures++; $display("FAIL bp_ready got=%0b exp=00", {req1_if.ready, req0_if.ready}); end
        step();
        req0_if.valid = 1'b0;
        req1_if.valid = 1'b0;
        checks++; if (acc_log.size() !== 2) begin failures++; $display("FAIL bp_accepts got=%0d exp=2", acc_log.size()); end
        rsp_ready = 1'b1;
        repeat (4) step();
        checks++; if (rsp_log.size() !== 2) begin failures++; $display("FAIL bp_rsps got=%0d exp=2", rsp_log.size()); end
        else begin
            checks++;
            if (rsp_log[0].id !== 0 || rsp_log[1].id !== 1 || rsp_log[1].res !== 32'd202 ||
                rsp_log[1].cyc !== rsp_log[0].cyc + 1) begin
                failures++;
                $display("FAIL bp_release got=id%0d,%0d c%0d,%0d exp=id0,1 consecutive", rsp_log[0].id, rsp_log[1].id, rsp_log[0].cyc, rsp_log[1].cyc);
            end
        end
    endtask

    task automatic test_branch();
        do_reset();
        rsp_ready = 1'b1;
        set_req(1, 1'b1, OP_BRANCH, BR_BEQ, 32'h80000000, 32'h80000000, 32'h40, 32'h8, 1'b0, 1'b0, 4'd5);
        step();
        set_req(1, 1'b1, OP_BRANCH, BR_BEQ, 32'h80000000, 32'h0, 32'h40, 32'h8, 1'b0, 1'b0, 4'd6);
        step();
        req1_if.valid = 1'b0;
        repeat (3) step();
        checks++; if (rsp_log.size() !== 2) begin failures++; $display("FAIL br_count got=%0d exp=2", rsp_log.size()); end
        else begin
            checks++; if (rsp_log[0].br !== 1'b1 || rsp_log[0].id !== 1) begin failures++; $display("FAIL br_beq_eq got=%0h/%0d exp=1/1", rsp_log[0].br, rsp_log[0].id); end
            checks++; if (rsp_log[1].br !== 1'b0 || rsp_log[1].tag !== 6) begin failures++; $display("FAIL br_beq_ne got=%0h/%0d exp=0/6", rsp_log[1].br, rsp_log[1].tag); end
        end
    endtask

    task automatic test_flush();
        do_reset();
        rsp_ready = 1'b0;
        set_req(0, 1'b1, OP_ALU, ALU_ADD, 32'd1, 32'd1, 32'h0, 32'h0, 1'b0, 1'b0, 4'd1);
        step();
        step();
        checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL fl_pre_rsp got=%0h exp=1", rsp_valid); end
        flush = 1'b1;
        rsp_ready = 1'b1;
        #1;
        checks++; if (req0_if.ready !== 1'b0) begin failures++; $display("FAIL fl_ready got=%0h exp=0", req0_if.ready); end
        step();
        flush = 1'b0;
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL fl_rsp_clr got=%0h exp=0", rsp_valid); end
        checks++; if (acc_log.size() !== 2) begin failures++; $display("FAIL fl_no_accept got=%0d exp=2", acc_log.size()); end
        #1;
        checks++; if (req0_if.ready !== 1'b1) begin failures++; $display("FAIL fl_after_ready got=%0h exp=1", req0_if.ready); end
        step();
        req0_if.valid = 1'b0;
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL fl_iss_clr got=%0h exp=0", rsp_valid); end
        step();
        checks++; if (rsp_valid !== 1'b1 || rsp_result !== 32'd2) begin failures++; $display("FAIL fl_post_rsp got=%0h/%0d exp=1/2", rsp_valid, rsp_result); end
    endtask

    task automatic test_stall_and_mid_reset();
        do_reset();
        rsp_ready = 1'b0;
        set_req(0, 1'b1, OP_ALU, ALU_XOR, 32'hF0, 32'h0F, 32'h0, 32'h0, 1'b0, 1'b0, 4'd9);
        repeat (10) step();
        checks++; if (stall_count !== EXP_STALL) begin failures++; $display("FAIL stall_count got=%0d exp=%0d", stall_count, EXP_STALL); end
        checks++; if (rsp_valid !== 1'b1 || rsp_result !== 32'hFF) begin failures++; $display("FAIL stall_rsp got=%0h/%0h exp=1/ff", rsp_valid, rsp_result); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        req0_if.valid = 1'b0;
        checks++; if (rsp_valid !== 1'b0 || rsp_result !== 32'h0 || alu_rs1 !== 32'h0) begin failures++; $display("FAIL mid_reset got=%0h/%0h/%0h exp=0/0/0", rsp_valid, rsp_result, alu_rs1); end
        checks++; if (stall_count !== 32'h0) begin failures++; $display("FAIL mid_reset_stall got=%0d exp=0", stall_count); end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_operand_paths();
        test_contention();
        test_backpressure();
        test_branch();
        test_flush();
        test_stall_and_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
